// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp floating-point units (adder and divider).
// Field layout, special encodings, FSM state enum and widths live here.
package ahfp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 24;
  localparam int REM_W    = 26;
  localparam int QUO_W    = 25;
  localparam int EXP_W    = 10;

  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2
  } ahfp_state_e;

  // Signed infinity; also the saturation value on exponent overflow.
  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, FP_POS_INF[30:0]};
  endfunction

endpackage

// File: rtl/ahfp_div_step.sv
// One restoring-division step: subtract the divisor if it fits, emit the
// quotient bit and return the remainder shifted left for the next bit.
module ahfp_div_step
  import ahfp_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic [MANT_W-1:0] divisor,
  output logic [REM_W-1:0]  next_rem,
  output logic              qbit
);

  logic [REM_W-1:0] w_div_ext;
  logic [REM_W-1:0] w_diff;
  logic [REM_W-1:0] w_sel;

  assign w_div_ext = {{(REM_W-MANT_W){1'b0}}, divisor};
  assign qbit      = (rem >= w_div_ext);
  assign w_diff    = rem - w_div_ext;
  assign w_sel     = qbit ? w_diff : rem;
  assign next_rem  = w_sel << 1;

endmodule

// File: rtl/ahfp_div_multi.sv
// Multi-cycle IEEE-754 single divider, one quotient bit per enabled cycle,
// with flush-to-zero and saturate-to-infinity range handling.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start; operands unpacked and classified
//   ST_DIV   | 25 restoring steps, quotient MSB first
//   ST_ROUND | round-half-up, range check, register result, pulse done
module ahfp_div_multi
  import ahfp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  fp32_t                    w_a;
  fp32_t                    w_b;
  logic                     w_a_zero;
  logic                     w_b_zero;
  logic                     w_sign;
  logic [MANT_W-1:0]        w_ma;
  logic [MANT_W-1:0]        w_mb;
  logic                     w_ma_lt;
  logic [EXP_W-1:0]         w_e_raw;
  logic [31:0]              w_spec_res;

  logic [REM_W-1:0]         w_next_rem;
  logic                     w_qbit;

  logic [QUO_W-1:0]         w_m;
  logic                     w_m_ovf;
  logic [22:0]              w_frac;
  logic signed [EXP_W-1:0]  w_e_rnd;
  logic [31:0]              w_packed;

  ahfp_state_e              r_state;
  logic [4:0]               r_cnt;
  logic [REM_W-1:0]         r_rem;
  logic [MANT_W-1:0]        r_mb;
  logic [QUO_W-1:0]         r_q;
  logic signed [EXP_W-1:0]  r_exp;
  logic                     r_sign;
  logic                     r_special;
  logic [31:0]              r_spec_res;
  logic                     r_done;
  logic [31:0]              r_result;

  assign w_a      = dataa;
  assign w_b      = datab;
  assign w_a_zero = (w_a.exp == 8'd0);
  assign w_b_zero = (w_b.exp == 8'd0);
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_ma     = {1'b1, w_a.frac};
  assign w_mb     = {1'b1, w_b.frac};
  assign w_ma_lt  = (w_ma < w_mb);

  // Pre-normalising the dividend guarantees the quotient MSB is 1.
  assign w_e_raw = {2'b00, w_a.exp} - {2'b00, w_b.exp} + EXP_W'(EXP_BIAS)
                 - {{(EXP_W-1){1'b0}}, w_ma_lt};

  always_comb begin
    w_spec_res = 32'd0;
    if (w_a_zero && w_b_zero) w_spec_res = FP_QNAN;
    else if (w_b_zero)        w_spec_res = fp_inf(w_sign);
  end

  ahfp_div_step u_step (
    .rem      (r_rem),
    .divisor  (r_mb),
    .next_rem (w_next_rem),
    .qbit     (w_qbit)
  );

  // q[0] is the guard bit; a carry out of rounding renormalises by one.
  assign w_m     = {1'b0, r_q[QUO_W-1:1]} + {{(QUO_W-1){1'b0}}, r_q[0]};
  assign w_m_ovf = w_m[QUO_W-1];
  assign w_frac  = w_m_ovf ? w_m[23:1] : w_m[22:0];
  assign w_e_rnd = r_exp + {{(EXP_W-1){1'b0}}, w_m_ovf};

  always_comb begin
    w_packed = {r_sign, w_e_rnd[7:0], w_frac};
    if (w_e_rnd <= 10'sd0)        w_packed = 32'd0;
    else if (w_e_rnd >= 10'sd255) w_packed = fp_inf(r_sign);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 5'd0;
      r_rem      <= '0;
      r_mb       <= '0;
      r_q        <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= 32'd0;
      r_done     <= 1'b0;
      r_result   <= 32'd0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign <= w_sign;
            if (w_a_zero || w_b_zero) begin
              r_special  <= 1'b1;
              r_spec_res <= w_spec_res;
              r_state    <= ST_ROUND;
            end else begin
              r_special <= 1'b0;
              r_rem     <= w_ma_lt ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
              r_mb      <= w_mb;
              r_exp     <= w_e_raw;
              r_q       <= '0;
              r_cnt     <= 5'd0;
              r_state   <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          r_rem <= w_next_rem;
          r_q   <= {r_q[QUO_W-2:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd24) r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_result <= r_special ? r_spec_res : w_packed;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_ahfp_div_multi.sv
// Bench for ahfp_div_multi: directed corner cases, handshake/stall/reset
// timing, and random operands against an integer-division reference model.
module tb_ahfp_div_multi;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  ahfp_div_multi dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  // Quotient as a whole-number division of the scaled mantissas.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int     ea;
    int     eb;
    int     e;
    logic   s;
    longint ma;
    longint mb;
    longint q;
    longint m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 0 && eb == 0) return 32'h7FC00000;
    if (eb == 0)            return {s, 8'hFF, 23'd0};
    if (ea == 0)            return 32'd0;
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    q = (ma * 64'd16777216) / mb;
    m = (q / 2) + (q % 2);
    if (m >= 64'd16777216) begin
      m = m / 2;
      e = e + 1;
    end
    if (e <= 0)   return 32'd0;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input int exp_lo, input int exp_hi, input bit allow_zero);
    logic [7:0] e;
    if (allow_zero && $urandom_range(0, 7) == 0) e = 8'd0;
    else e = 8'($urandom_range(exp_lo, exp_hi));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
    int lat;
    int exp_lat;
    exp_lat = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 26;
    run_op(a, b, lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, result, exp_res);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          lat;
    int          n_done;
    int          first_k;
    int          second_k;

    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    dataa   = 32'd0;
    datab   = 32'd0;
    #2;
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.result", result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    check_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000);
    check_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    check_op("neg_two",    32'hC0000000, 32'h3F800000, 32'hC0000000);
    check_op("neg_div0",   32'hBF800000, 32'h00000000, 32'hFF800000);
    check_op("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000);
    check_op("zero_num",   32'h00000000, 32'h40000000, 32'h00000000);
    check_op("overflow",   32'h7F000000, 32'h00800000, 32'h7F800000);
    check_op("underflow",  32'h00800000, 32'h7F000000, 32'h00000000);

    for (int i = 0; i < 30; i++) begin
      a = rand_fp(1, 255, 1'b1);
      b = rand_fp(1, 255, 1'b1);
      check_op($sformatf("rnd%0d", i), a, b, ref_div(a, b));
    end

    // start held high: second operation accepted the cycle done is high
    a = rand_fp(100, 150, 1'b0);
    b = rand_fp(100, 150, 1'b0);
    exp_res = ref_div(a, b);
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_done   = 0;
    first_k  = 0;
    second_k = 0;
    for (int k = 1; k <= 53; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n_done++;
        if (first_k == 0) first_k = k;
        else second_k = k;
      end
    end
    start = 1'b0;
    check("hold.first_done", 32'(first_k), 32'd26);
    check("hold.second_done", 32'(second_k), 32'd53);
    check("hold.n_done", 32'(n_done), 32'd2);
    check("hold.res", result, exp_res);
    @(posedge clk);
    #1;
    check("hold.pulse", {31'd0, done}, 32'd0);

    // five stalled cycles mid-division, then a stretched done pulse
    @(negedge clk);
    dataa = 32'h3F800000;
    datab = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      clk_en = (lat >= 10 && lat < 15) ? 1'b0 : 1'b1;
    end
    clk_en = 1'b1;
    check("stall.lat", 32'(lat), 32'd31);
    check("stall.res", result, 32'h3EAAAAAB);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stretch.done", {31'd0, done}, 32'd1);
    check("stretch.res", result, 32'h3EAAAAAB);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("stretch.release", {31'd0, done}, 32'd0);

    // reset at edge 10 of a division aborts it
    @(negedge clk);
    dataa = 32'h40C00000;
    datab = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
